// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Imported by the arbiter top level and its wait counter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_e;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 3;
    localparam int unsigned CNT_W               = 4;

    // Counter preload: the grant edge already counts as the first held cycle.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
        return CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Load/decrement down-counter with a terminal-count flag.
// Holds at zero; load takes priority over decrement.
module arb_wait_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one SRAM port between instruction fetch and MEM-stage load/store,
// holding each access for WAIT_CYCLES cycles and returning a one-cycle ready pulse.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy,
    output logic              req_err
);

    localparam logic [CNT_W-1:0] LOAD_VAL = wait_load(WAIT_CYCLES);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              err_q, err_d;
    logic              cnt_load, cnt_dec, cnt_tc;

    arb_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(LOAD_VAL),
        .tc      (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        en_d        = en_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        err_d       = err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_wr_req) begin
                    owner_d = OWN_MEM;
                    we_d    = 1'b1;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    if (mem_rd_req) begin
                        err_d = 1'b1;
                    end
                end else if (mem_rd_req) begin
                    owner_d = OWN_MEM;
                    we_d    = 1'b0;
                    addr_d  = mem_addr;
                end else if (if_req) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                end
                if (mem_wr_req || mem_rd_req || if_req) begin
                    en_d     = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_tc) begin
                    // sram_rdata is only trusted on the last held edge.
                    if (!we_q) begin
                        if (owner_q == OWN_MEM) begin
                            mem_rdata_d = sram_rdata;
                        end else begin
                            if_rdata_d = sram_rdata;
                        end
                    end
                    en_d        = 1'b0;
                    we_d        = 1'b0;
                    if_ready_d  = (owner_q == OWN_IF);
                    mem_ready_d = (owner_q == OWN_MEM);
                    state_d     = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            err_q       <= err_d;
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign sram_en    = en_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = (state_q != IDLE);
    assign req_err    = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance 0 uses WAIT_CYCLES=3, instance 1 uses WAIT_CYCLES=1.
// A cycle-count model predicts every output; directed tests pin latencies and data.
module tb_sram_arbiter;

    localparam int WV [2] = '{3, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        ifq [2];
    logic        rdq [2];
    logic        wrq [2];
    logic [31:0] ifa [2];
    logic [31:0] ma  [2];
    logic [31:0] wd  [2];

    logic [31:0] if_rd  [2];
    logic [31:0] mem_rd [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wd   [2];
    logic [31:0] s_rdata[2];
    logic        ifr    [2];
    logic        memr   [2];
    logic        s_en   [2];
    logic        s_we   [2];
    logic        bsy    [2];
    logic        err    [2];

    logic [31:0] sram [2][64];
    logic [31:0] mm   [2][64];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.WAIT_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(ifq[0]), .if_addr(ifa[0]), .if_rdata(if_rd[0]), .if_ready(ifr[0]),
        .mem_rd_req(rdq[0]), .mem_wr_req(wrq[0]), .mem_addr(ma[0]), .mem_wdata(wd[0]),
        .mem_rdata(mem_rd[0]), .mem_ready(memr[0]),
        .sram_en(s_en[0]), .sram_we(s_we[0]), .sram_addr(s_addr[0]), .sram_wdata(s_wd[0]),
        .sram_rdata(s_rdata[0]), .busy(bsy[0]), .req_err(err[0])
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(ifq[1]), .if_addr(ifa[1]), .if_rdata(if_rd[1]), .if_ready(ifr[1]),
        .mem_rd_req(rdq[1]), .mem_wr_req(wrq[1]), .mem_addr(ma[1]), .mem_wdata(wd[1]),
        .mem_rdata(mem_rd[1]), .mem_ready(memr[1]),
        .sram_en(s_en[1]), .sram_we(s_we[1]), .sram_addr(s_addr[1]), .sram_wdata(s_wd[1]),
        .sram_rdata(s_rdata[1]), .busy(bsy[1]), .req_err(err[1])
    );

    function automatic logic [31:0] init_word(input int i, input int j);
        if (i == 0) begin
            case (j)
                4:       return 32'hE3A00001;
                5:       return 32'hA0B0C0D0;
                32:      return 32'h12345678;
                default: return 32'h0;
            endcase
        end
        return (j == 0) ? 32'h0000A5A5 : 32'h0;
    endfunction

    // Bench SRAM: asynchronous read, write on every enabled write cycle.
    assign s_rdata[0] = sram[0][s_addr[0][7:2]];
    assign s_rdata[1] = sram[1][s_addr[1][7:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cyc == 0) begin
                for (int j = 0; j < 64; j++) sram[i][j] <= init_word(i, j);
            end else if (s_en[i] && s_we[i]) begin
                sram[i][s_addr[i][7:2]] <= s_wd[i];
            end
        end
    end

    task automatic chk(input int i, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s at cycle %0d: got %h, expected %h", i, nm, cyc, act, exp);
        end
    endtask

    // Model: an access granted at relative edge 0 holds the bus through edge W-1,
    // completes at edge W (ready visible), and frees the port after edge W+1.
    bit          act    [2];
    int          mk     [2];
    bit          m_mem  [2];
    logic        e_en   [2];
    logic        e_we   [2];
    logic        e_ifr  [2];
    logic        e_memr [2];
    logic        e_busy [2];
    logic        e_err  [2];
    logic [31:0] e_addr [2];
    logic [31:0] e_wd   [2];
    logic [31:0] e_ifrd [2];
    logic [31:0] e_memrd[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cyc == 0) begin
                for (int j = 0; j < 64; j++) mm[i][j] <= init_word(i, j);
            end
            if (rst) begin
                act[i]     <= 1'b0;
                mk[i]      <= 0;
                e_en[i]    <= 1'b0;
                e_we[i]    <= 1'b0;
                e_ifr[i]   <= 1'b0;
                e_memr[i]  <= 1'b0;
                e_busy[i]  <= 1'b0;
                e_err[i]   <= 1'b0;
                e_ifrd[i]  <= '0;
                e_memrd[i] <= '0;
            end else if (!act[i]) begin
                e_ifr[i]  <= 1'b0;
                e_memr[i] <= 1'b0;
                if (wrq[i] || rdq[i] || ifq[i]) begin
                    act[i]    <= 1'b1;
                    mk[i]     <= 0;
                    e_en[i]   <= 1'b1;
                    e_busy[i] <= 1'b1;
                    m_mem[i]  <= wrq[i] || rdq[i];
                    e_we[i]   <= wrq[i];
                    e_addr[i] <= (wrq[i] || rdq[i]) ? ma[i] : ifa[i];
                    if (wrq[i]) begin
                        e_wd[i] <= wd[i];
                        mm[i][ma[i][7:2]] <= wd[i];
                    end
                    if (wrq[i] && rdq[i]) e_err[i] <= 1'b1;
                end
            end else begin
                if (mk[i] + 1 == WV[i]) begin
                    e_en[i] <= 1'b0;
                    e_we[i] <= 1'b0;
                    if (m_mem[i]) e_memr[i] <= 1'b1;
                    else          e_ifr[i]  <= 1'b1;
                    if (!e_we[i]) begin
                        if (m_mem[i]) e_memrd[i] <= mm[i][e_addr[i][7:2]];
                        else          e_ifrd[i]  <= mm[i][e_addr[i][7:2]];
                    end
                end else if (mk[i] + 1 == WV[i] + 1) begin
                    e_ifr[i]  <= 1'b0;
                    e_memr[i] <= 1'b0;
                    e_busy[i] <= 1'b0;
                    act[i]    <= 1'b0;
                end
                mk[i] <= mk[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                chk(i, "if_ready", ifr[i], e_ifr[i]);
                chk(i, "mem_ready", memr[i], e_memr[i]);
                chk(i, "sram_en", s_en[i], e_en[i]);
                chk(i, "sram_we", s_we[i], e_we[i]);
                chk(i, "busy", bsy[i], e_busy[i]);
                chk(i, "req_err", err[i], e_err[i]);
                chk(i, "if_rdata", if_rd[i], e_ifrd[i]);
                chk(i, "mem_rdata", mem_rd[i], e_memrd[i]);
                if (e_en[i]) chk(i, "sram_addr", s_addr[i], e_addr[i]);
                if (e_en[i] && e_we[i]) chk(i, "sram_wdata", s_wd[i], e_wd[i]);
            end
        end
    end

    // Waits (bounded) for a ready pulse; lat counts edges from the calling negedge.
    task automatic wait_rdy(input int i, input bit mem, output int lat, output int n_en,
                            output int n_we);
        int  c0;
        bit  seen;
        c0   = cyc;
        seen = 1'b0;
        n_en = 0;
        n_we = 0;
        lat  = 999;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (s_en[i]) n_en++;
            if (s_we[i]) n_we++;
            if (mem ? memr[i] : ifr[i]) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lat2, ne, nw, pulses;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifq[i] = 1'b0; rdq[i] = 1'b0; wrq[i] = 1'b0;
            ifa[i] = '0;   ma[i]  = '0;   wd[i]  = '0;
        end
        repeat (3) @(negedge clk);
        chk(0, "reset busy", bsy[0], 0);
        chk(0, "reset sram_en", s_en[0], 0);
        chk(0, "reset if_ready", ifr[0], 0);
        chk(0, "reset if_rdata", if_rd[0], 0);
        chk(1, "reset req_err", err[1], 0);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);

        // Instruction fetch.
        ifq[0] = 1'b1; ifa[0] = 32'h10;
        wait_rdy(0, 1'b0, lat, ne, nw);
        ifq[0] = 1'b0;
        chk(0, "t1 latency", lat, 4);
        chk(0, "t1 en cycles", ne, 3);
        chk(0, "t1 if_rdata", if_rd[0], 32'hE3A00001);
        repeat (2) @(negedge clk);

        // Store and fetch rise together; store wins.
        wrq[0] = 1'b1; ma[0] = 32'h40; wd[0] = 32'hDEADBEEF;
        ifq[0] = 1'b1; ifa[0] = 32'h14;
        wait_rdy(0, 1'b1, lat, ne, nw);
        wrq[0] = 1'b0;
        chk(0, "t2 store latency", lat, 4);
        chk(0, "t2 we cycles", nw, 3);
        wait_rdy(0, 1'b0, lat2, ne, nw);
        ifq[0] = 1'b0;
        chk(0, "t2 fetch ready cycle", lat + lat2, 9);
        chk(0, "t2 fetch data", if_rd[0], 32'hA0B0C0D0);
        chk(0, "t2 mem_rdata kept", mem_rd[0], 0);
        chk(0, "t2 sram stored", sram[0][16], 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        // Load then store: store leaves mem_rdata alone.
        rdq[0] = 1'b1; ma[0] = 32'h80;
        wait_rdy(0, 1'b1, lat, ne, nw);
        rdq[0] = 1'b0;
        chk(0, "t3 load data", mem_rd[0], 32'h12345678);
        repeat (2) @(negedge clk);
        wrq[0] = 1'b1; ma[0] = 32'h84; wd[0] = 32'h00000055;
        wait_rdy(0, 1'b1, lat, ne, nw);
        wrq[0] = 1'b0;
        chk(0, "t3 mem_rdata after store", mem_rd[0], 32'h12345678);
        repeat (2) @(negedge clk);

        // Reset in the second BUSY cycle of a fetch.
        ifq[0] = 1'b1; ifa[0] = 32'h10;
        repeat (2) @(negedge clk);
        rst = 1'b1; ifq[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk(0, "t4 sram_en after rst", s_en[0], 0);
        chk(0, "t4 busy after rst", bsy[0], 0);
        chk(0, "t4 mem_rdata after rst", mem_rd[0], 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifr[0] || memr[0]) pulses++;
        end
        chk(0, "t4 no ready after rst", pulses, 0);
        ifq[0] = 1'b1; ifa[0] = 32'h10;
        wait_rdy(0, 1'b0, lat, ne, nw);
        ifq[0] = 1'b0;
        chk(0, "t4 fresh latency", lat, 4);
        chk(0, "t4 fresh data", if_rd[0], 32'hE3A00001);
        repeat (2) @(negedge clk);

        // Conflicting load and store.
        rdq[0] = 1'b1; wrq[0] = 1'b1; ma[0] = 32'h88; wd[0] = 32'hCAFEF00D;
        wait_rdy(0, 1'b1, lat, ne, nw);
        rdq[0] = 1'b0; wrq[0] = 1'b0;
        chk(0, "t5 req_err set", err[0], 1);
        chk(0, "t5 write done", sram[0][34], 32'hCAFEF00D);
        chk(0, "t5 we cycles", nw, 3);
        repeat (6) @(negedge clk);
        chk(0, "t5 req_err sticky", err[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(0, "t5 req_err cleared", err[0], 0);
        @(negedge clk);

        // WAIT_CYCLES=1 with a continuous fetch request.
        ifq[1] = 1'b1; ifa[1] = 32'h0;
        wait_rdy(1, 1'b0, lat, ne, nw);
        chk(1, "t6 first latency", lat, 2);
        chk(1, "t6 first en cycles", ne, 1);
        chk(1, "t6 data", if_rd[1], 32'h0000A5A5);
        for (int k = 0; k < 3; k++) begin
            wait_rdy(1, 1'b0, lat, ne, nw);
            chk(1, "t6 ready spacing", lat, 3);
            chk(1, "t6 en per access", ne, 1);
        end
        ifq[1] = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
